// File: rtl/if_id_stage_ctrl.sv
// IF/ID pipeline register and front-end controller: turns load-use stalls,
// EX-stage flushes and multi-cycle mult/div occupancy into register actions.
module if_id_stage_ctrl #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      fetch_ins,
  input  logic [31:0]      fetch_pc4,
  output logic             pc_we,
  output logic [31:0]      if_id_ins,
  output logic [31:0]      if_id_pc4,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MC_W = $clog2(MC_CYCLES);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MCBUSY  = 2'd2
  } state_t;

  state_t          state;
  logic [MC_W-1:0] mc_cnt;
  logic            mc_issue;
  logic            take_flush;
  logic            take_stall;

  // mult, multu, div, divu: SPECIAL opcode with funct 0x18..0x1B
  assign mc_issue = (if_id_ins[31:26] == 6'd0) && (if_id_ins[5:2] == 4'b0110);

  // A stall seen in LDSTALL is the same frozen request, so it is honoured once.
  assign take_flush = (state != MCBUSY) && flush;
  assign take_stall = (state == RUN) && stall && !flush;
  assign mc_busy    = (state == MCBUSY);

  always_comb begin
    pc_we        = 1'b1;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state == MCBUSY) begin
      pc_we      = 1'b0;
      id_ex_hold = 1'b1;
    end else if (take_flush) begin
      id_ex_bubble = 1'b1;
    end else if (take_stall) begin
      pc_we        = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      if_id_ins    <= '0;
      if_id_pc4    <= '0;
      mc_cnt       <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (state == MCBUSY) begin
      if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      mc_cnt <= mc_cnt - MC_W'(1);
      if (mc_cnt == MC_W'(1)) state <= RUN;
    end else if (take_flush) begin
      if_id_ins <= '0;
      if_id_pc4 <= '0;
      if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      state <= RUN;
    end else if (take_stall) begin
      if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      state <= LDSTALL;
    end else begin
      if_id_ins <= fetch_ins;
      if_id_pc4 <= fetch_pc4;
      if (mc_issue) begin
        mc_cnt <= MC_W'(MC_CYCLES - 1);
        state  <= MCBUSY;
      end else begin
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Bench for if_id_stage_ctrl: directed scenarios plus random traffic, checked
// every cycle against a cycle-level behavioural model of the front end.
module tb_if_id_stage_ctrl;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic [31:0] fetch_ins, fetch_pc4;

  logic        pc_we, id_ex_bubble, id_ex_hold, mc_busy;
  logic [31:0] if_id_ins, if_id_pc4;
  logic [15:0] stall_cycles, flush_count;

  logic        s_pc_we, s_id_ex_bubble, s_id_ex_hold, s_mc_busy;
  logic [31:0] s_if_id_ins, s_if_id_pc4;
  logic [1:0]  s_stall_cycles, s_flush_count;

  if_id_stage_ctrl #(.MC_CYCLES(MC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .fetch_ins(fetch_ins), .fetch_pc4(fetch_pc4),
    .pc_we(pc_we), .if_id_ins(if_id_ins), .if_id_pc4(if_id_pc4),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .mc_busy(mc_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  if_id_stage_ctrl #(.MC_CYCLES(MC), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .fetch_ins(fetch_ins), .fetch_pc4(fetch_pc4),
    .pc_we(s_pc_we), .if_id_ins(s_if_id_ins), .if_id_pc4(s_if_id_pc4),
    .id_ex_bubble(s_id_ex_bubble), .id_ex_hold(s_id_ex_hold), .mc_busy(s_mc_busy),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: remaining busy cycles, whether the previous cycle was a
  // load-use stall, and unsaturated event counts.
  logic [31:0] m_ins, m_pc4;
  int          m_busy_left;
  bit          m_ld;
  int          m_stalls, m_flushes;

  function automatic bit is_mc(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) &&
           (ins[5:0] == 6'h18 || ins[5:0] == 6'h19 || ins[5:0] == 6'h1A || ins[5:0] == 6'h1B);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f,
                      input logic [31:0] ins, input logic [31:0] pc4);
    bit e_we, e_bub, e_hold, e_busy;
    rst_n = r; stall = s; flush = f; fetch_ins = ins; fetch_pc4 = pc4;
    e_busy = (m_busy_left > 0);
    if (!r)                 begin e_we = 0; e_bub = 1; e_hold = 0; end
    else if (m_busy_left>0) begin e_we = 0; e_bub = 0; e_hold = 1; end
    else if (f)             begin e_we = 1; e_bub = 1; e_hold = 0; end
    else if (s && !m_ld)    begin e_we = 0; e_bub = 1; e_hold = 0; end
    else                    begin e_we = 1; e_bub = 0; e_hold = 0; end
    @(negedge clk);
    chk("pc_we", {31'd0, pc_we}, {31'd0, e_we});
    chk("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, e_bub});
    chk("id_ex_hold", {31'd0, id_ex_hold}, {31'd0, e_hold});
    chk("mc_busy", {31'd0, mc_busy}, {31'd0, e_busy});
    chk("if_id_ins", if_id_ins, m_ins);
    chk("if_id_pc4", if_id_pc4, m_pc4);
    chk("stall_cycles", {16'd0, stall_cycles}, 32'(sat(m_stalls, 65535)));
    chk("flush_count", {16'd0, flush_count}, 32'(sat(m_flushes, 65535)));
    chk("s_pc_we", {31'd0, s_pc_we}, {31'd0, e_we});
    chk("s_stall_cycles", {30'd0, s_stall_cycles}, 32'(sat(m_stalls, 3)));
    chk("s_flush_count", {30'd0, s_flush_count}, 32'(sat(m_flushes, 3)));
    @(posedge clk);
    if (!r) begin
      m_ins = 0; m_pc4 = 0; m_busy_left = 0; m_ld = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--; m_stalls++; m_ld = 0;
    end else if (f) begin
      m_ins = 0; m_pc4 = 0; m_flushes++; m_ld = 0;
    end else if (s && !m_ld) begin
      m_stalls++; m_ld = 1;
    end else begin
      if (is_mc(m_ins)) m_busy_left = MC - 1;
      m_ins = ins; m_pc4 = pc4; m_ld = 0;
    end
    #1;
  endtask

  task automatic go(input logic [31:0] ins, input logic [31:0] pc4);
    step(1, 0, 0, ins, pc4);
  endtask

  initial begin
    logic [31:0] rins;
    rst_n = 0; stall = 0; flush = 0; fetch_ins = 32'h8C010004; fetch_pc4 = 32'h4;
    @(posedge clk); #1;
    m_ins = 0; m_pc4 = 0; m_busy_left = 0; m_ld = 0; m_stalls = 0; m_flushes = 0;

    // Reset, then release loads the waiting fetch.
    step(0, 0, 0, 32'h8C010004, 32'h4);
    step(0, 0, 0, 32'h8C010004, 32'h4);
    go(32'h8C010004, 32'h4);
    chk("lit_reset_release_ins", if_id_ins, 32'h8C010004);

    // Normal flow.
    go(32'h20010001, 32'h8);
    go(32'h20020002, 32'hC);
    chk("lit_normal_ins", if_id_ins, 32'h20020002);

    // Load-use held two cycles: honoured once.
    go(32'h8C220000, 32'h10);
    step(1, 1, 0, 32'h00430820, 32'h14);
    step(1, 1, 0, 32'h00430820, 32'h14);
    chk("lit_loaduse_stalls", {16'd0, stall_cycles}, 32'd1);
    chk("lit_loaduse_ins", if_id_ins, 32'h00430820);

    // Flush beats stall.
    step(0, 0, 0, 32'h0, 32'h0);
    go(32'h20010001, 32'h8);
    step(1, 1, 1, 32'h20030003, 32'h10);
    chk("lit_flush_ins", if_id_ins, 32'h0);
    chk("lit_flush_pc4", if_id_pc4, 32'h0);
    chk("lit_flush_count", {16'd0, flush_count}, 32'd1);
    chk("lit_flush_stalls", {16'd0, stall_cycles}, 32'd0);

    // mult: advance edge, then MC-1 busy cycles; flush in busy cycle 2 ignored.
    step(0, 0, 0, 32'h0, 32'h0);
    go(32'h00220018, 32'h20);
    go(32'h20050005, 32'h24);
    chk("lit_mc_busy_on", {31'd0, mc_busy}, 32'd1);
    go(32'h20060006, 32'h28);
    step(1, 0, 1, 32'h20060006, 32'h28);
    go(32'h20060006, 32'h28);
    chk("lit_mc_busy_off", {31'd0, mc_busy}, 32'd0);
    chk("lit_mc_stalls", {16'd0, stall_cycles}, 32'd3);
    chk("lit_mc_flushes", {16'd0, flush_count}, 32'd0);
    chk("lit_mc_ins", if_id_ins, 32'h20050005);

    // Five separate load-use stalls saturate the 2-bit counter.
    step(0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      go(32'h8C220000, 32'h40);
      step(1, 1, 0, 32'h00430820, 32'h44);
      go(32'h00430820, 32'h44);
    end
    chk("lit_sat_small", {30'd0, s_stall_cycles}, 32'd3);
    chk("lit_sat_wide", {16'd0, stall_cycles}, 32'd5);

    // Reset in busy cycle 2.
    go(32'h00220019, 32'h50);
    go(32'h20070007, 32'h54);
    go(32'h20070007, 32'h54);
    step(0, 0, 0, 32'h20070007, 32'h54);
    chk("lit_rst_busy", {31'd0, mc_busy}, 32'd0);
    chk("lit_rst_stalls", {16'd0, stall_cycles}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: rins = {6'd0, 20'($urandom), 4'b0110, 2'($urandom)};
        1: rins = {6'd0, 20'($urandom), 6'($urandom_range(6'h1C, 6'h17))};
        default: rins = $urandom;
      endcase
      step($urandom_range(59) != 0, $urandom_range(2) == 0, $urandom_range(5) == 0,
           rins, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage_ctrl.md
Name: if_id_stage_ctrl

Overview:
- Front-end pipeline controller: owns the IF/ID pipeline register and turns the hazard unit's stall requests, EX-stage branch flushes and multi-cycle multiply/divide occupancy into concrete register actions.
- Actions driven: PC write-enable, IF/ID load/hold/clear, ID/EX bubble insert, ID/EX hold.
- Sits between the fetch stage and the ID/EX register. Consumes hazard_control's stall; supplies the IF/ID instruction that hazard_control inspects.

Parameters:
- MC_CYCLES, 4, total EX-stage cycles of mult/multu/div/divu (legal range ≥2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- stall  in  1  load-use stall request from hazard_control.
- flush  in  1  taken branch/jump resolved in EX; the instruction in ID is wrong-path.
- fetch_ins  in  32  instruction from instruction memory.
- fetch_pc4  in  32  PC+4 of fetch_ins.
- pc_we  out  1  PC write-enable (combinational).
- if_id_ins  out  32  IF/ID instruction register.
- if_id_pc4  out  32  IF/ID PC+4 register.
- id_ex_bubble  out  1  ID/EX loads all-zero control (nop); combinational.
- id_ex_hold  out  1  ID/EX and EX stage retain contents; combinational.
- mc_busy  out  1  high while in MCBUSY (combinational from state).
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0 outside reset.
- flush_count  out  CNT_W  saturating count of honoured flushes.

Behaviour:
- States: RUN, LDSTALL, MCBUSY. Internal down-counter mc_cnt of width clog2(MC_CYCLES).
- Reset, synchronous with rst_n low:
  - State=RUN; if_id_ins=0, if_id_pc4=0, mc_cnt=0, both counters=0.
  - Combinational outputs while rst_n low: pc_we=0, id_ex_bubble=1, id_ex_hold=0.
  - Reset overrides every state, including mid-MCBUSY.
- mc_issue: if_id_ins[31:26]==0 and if_id_ins[5:0] ∈ {0x18,0x19,0x1A,0x1B}.
- RUN, priority flush > stall > mc_issue > normal:
  - flush: pc_we=1, IF/ID<=0 (both registers), id_ex_bubble=1, flush_count++; next RUN.
  - stall: pc_we=0, IF/ID held, id_ex_bubble=1, stall_cycles++; next LDSTALL.
  - mc_issue: normal advance (pc_we=1, IF/ID<=fetch_*, bubble=0); mc_cnt<=MC_CYCLES-1; next MCBUSY.
  - normal: pc_we=1, IF/ID<=fetch_ins/fetch_pc4, bubble=0, hold=0; next RUN.
- LDSTALL:
  - stall input is ignored. hazard_control's stall is a function of the frozen IF/ID contents, so a load-use stall is honoured for exactly one cycle.
  - Otherwise identical to RUN (flush and mc_issue honoured with the same priority); next RUN or MCBUSY.
- MCBUSY:
  - pc_we=0, IF/ID held, id_ex_hold=1, id_ex_bubble=0, mc_busy=1, stall_cycles++ each cycle.
  - mc_cnt decrements each cycle. When mc_cnt==1, next state is RUN.
  - MCBUSY therefore lasts exactly MC_CYCLES-1 cycles.
  - stall and flush are ignored: EX holds the mult/div, so no branch can resolve.
- Counters saturate at all-ones; they never wrap.
- Outside reset, id_ex_bubble and id_ex_hold are never both 1.
- Registered outputs update only on the rising clk edge; combinational outputs are valid within the same cycle as their inputs/state.

Test Plan:
- Reset: rst_n=0 for 2 cycles, fetch_ins=0x8C010004 → if_id_ins=0, pc_we=0, id_ex_bubble=1, counters=0. After release, the first edge loads if_id_ins=0x8C010004.
- Normal flow: fetch 0x20010001 then 0x20020002, stall=flush=0 → each appears on if_id_ins one edge later; pc_we=1, bubble=0 throughout.
- Load-use: if_id_ins=0x8C220000, stall held high 2 cycles → exactly one cycle pc_we=0/bubble=1 (state LDSTALL), then advance; stall_cycles=1.
- Flush and stall asserted together in RUN → if_id_ins=0, if_id_pc4=0, pc_we=1, bubble=1, flush_count=1, stall_cycles=0.
- MC_CYCLES=4, if_id_ins=0x00220018 (mult) → advance edge, then 3 cycles with mc_busy=1, id_ex_hold=1, pc_we=0. A flush pulse in busy cycle 2 is ignored. Back to RUN; stall_cycles=3.
- Boundaries:
  - CNT_W=2: 5 separate load-use stalls → stall_cycles=3 (saturated).
  - rst_n low during MCBUSY cycle 2 → next edge RUN, mc_busy=0, counters=0.
